// File: rtl/paillier_pkg.sv
// Shared types and width helpers for the Paillier decryption engine.
package paillier_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL_N,
      MUL_NSQ,
      CHECK,
      EXP,
      LDIV,
      MUL_MU,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      SQ_ISSUE,
      SQ_WAIT,
      ML_ISSUE,
      ML_WAIT
   } phase_t;

   function automatic int n_width(input int pw);
      return 2 * pw;
   endfunction

   function automatic int c_width(input int pw);
      return 4 * pw;
   endfunction

endpackage

// File: rtl/paillier_modmul.sv
// Interleaved MSB-first shift-add modular multiplier: result = a*b mod m.
// Requires a < m; one load edge, W step edges, then a 1-cycle done pulse.
module paillier_modmul #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic [W-1:0] result,
   output logic         done
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  m_q;
   logic [W+1:0]  r_q;
   logic [W+1:0]  r_d;
   logic [W+1:0]  dbl;
   logic [W+1:0]  sum;
   logic [CW-1:0] cnt_q;
   logic          run_q;
   logic          done_q;

   // Two extra bits keep 2r and r+a (both < 2m) from overflowing.
   always_comb begin
      dbl = r_q << 1;
      if (dbl >= {2'b00, m_q})
         dbl = dbl - {2'b00, m_q};
      sum = dbl + (b_q[W-1] ? {2'b00, a_q} : '0);
      if (sum >= {2'b00, m_q})
         sum = sum - {2'b00, m_q};
      r_d = sum;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            r_q   <= '0;
            cnt_q <= CW'(W);
            run_q <= 1'b1;
         end else if (run_q) begin
            if (cnt_q != '0) begin
               r_q   <= r_d;
               b_q   <= b_q << 1;
               cnt_q <= cnt_q - 1'b1;
            end else begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign result = r_q[W-1:0];
   assign done   = done_q;

endmodule

// File: rtl/paillier_decrypt_param.sv
// Paillier decryption engine: m = L(c^lambda mod n^2) * mu mod n.
// Integer multiply/divide run here; modular products use one shared modmul.
module paillier_decrypt_param
   import paillier_pkg::*;
#(
   parameter int P_W = 32,
   parameter int N_W = n_width(P_W),
   parameter int C_W = c_width(P_W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [C_W-1:0] cipher_text,
   input  logic [P_W-1:0] p,
   input  logic [P_W-1:0] q,
   input  logic [N_W-1:0] lambda,
   input  logic [N_W-1:0] mu,
   output logic [N_W-1:0] out,
   output logic           done,
   output logic           busy,
   output logic           err
);
   localparam int CNT_W = $clog2(C_W + 1);

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [C_W-1:0]   c_q, c_d;
   logic [N_W-1:0]   lam_q, lam_d;
   logic [N_W-1:0]   mu_q, mu_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [C_W-1:0]   nsq_q, nsq_d;
   logic [C_W-1:0]   acc_q, acc_d;
   logic [C_W-1:0]   sh_q, sh_d;
   logic [N_W-1:0]   mp_q, mp_d;
   logic [N_W:0]     rem_q, rem_d;
   logic [N_W-1:0]   out_q, out_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             mm_start;
   logic             mm_done;
   logic [C_W-1:0]   mm_a;
   logic [C_W-1:0]   mm_b;
   logic [C_W-1:0]   mm_m;
   logic [C_W-1:0]   mm_res;
   logic [C_W-1:0]   sum;
   logic [N_W:0]     rt;
   logic             step;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         phase_q <= SQ_ISSUE;
         cnt_q   <= '0;
         c_q     <= '0;
         lam_q   <= '0;
         mu_q    <= '0;
         n_q     <= '0;
         nsq_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         mp_q    <= '0;
         rem_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         lam_q   <= lam_d;
         mu_q    <= mu_d;
         n_q     <= n_d;
         nsq_q   <= nsq_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         mp_q    <= mp_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // MUL_MU reuses the C_W-wide multiplier with L, mu and n zero-extended.
   assign mm_a = (state_q == MUL_MU) ? sh_q : acc_q;
   assign mm_b = (state_q == MUL_MU) ? {{(C_W-N_W){1'b0}}, mu_q} :
                 (phase_q == ML_ISSUE) ? c_q : acc_q;
   assign mm_m = (state_q == MUL_MU) ? {{(C_W-N_W){1'b0}}, n_q} : nsq_q;

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      lam_d    = lam_q;
      mu_d     = mu_q;
      n_d      = n_q;
      nsq_d    = nsq_q;
      acc_d    = acc_q;
      sh_d     = sh_q;
      mp_d     = mp_q;
      rem_d    = rem_q;
      out_d    = out_q;
      done_d   = done_q;
      err_d    = err_q;
      mm_start = 1'b0;
      step     = 1'b0;
      sum      = acc_q + (mp_q[0] ? sh_q : '0);
      rt       = (rem_q << 1) | {{N_W{1'b0}}, sh_q[C_W-1]};

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               c_d     = cipher_text;
               lam_d   = lambda;
               mu_d    = mu;
               sh_d    = {{(C_W-P_W){1'b0}}, p};
               mp_d    = {{(N_W-P_W){1'b0}}, q};
               acc_d   = '0;
               cnt_d   = CNT_W'(P_W);
               out_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = MUL_N;
            end
         end
         MUL_N, MUL_NSQ: begin
            acc_d = sum;
            sh_d  = sh_q << 1;
            mp_d  = mp_q >> 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               if (state_q == MUL_N) begin
                  n_d     = sum[N_W-1:0];
                  sh_d    = sum;
                  mp_d    = sum[N_W-1:0];
                  acc_d   = '0;
                  cnt_d   = CNT_W'(N_W);
                  state_d = MUL_NSQ;
               end else begin
                  nsq_d   = sum;
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (n_q == '0 || n_q == N_W'(1) ||
                c_q == '0 || c_q >= nsq_q) begin
               err_d   = 1'b1;
               out_d   = '0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               acc_d   = C_W'(1);
               cnt_d   = CNT_W'(N_W);
               phase_d = SQ_ISSUE;
               state_d = EXP;
            end
         end
         EXP: begin
            unique case (phase_q)
               SQ_ISSUE: begin
                  mm_start = 1'b1;
                  phase_d  = SQ_WAIT;
               end
               SQ_WAIT: begin
                  if (mm_done) begin
                     acc_d = mm_res;
                     if (lam_q[N_W-1])
                        phase_d = ML_ISSUE;
                     else
                        step = 1'b1;
                  end
               end
               ML_ISSUE: begin
                  mm_start = 1'b1;
                  phase_d  = ML_WAIT;
               end
               ML_WAIT: begin
                  if (mm_done) begin
                     acc_d = mm_res;
                     step  = 1'b1;
                  end
               end
               default: ;
            endcase
            if (step) begin
               lam_d   = lam_q << 1;
               cnt_d   = cnt_q - 1'b1;
               phase_d = SQ_ISSUE;
               if (cnt_q == CNT_W'(1)) begin
                  // acc==0 wraps to n^2-1 so L stays below n.
                  sh_d    = (acc_d == '0) ? nsq_q - 1'b1 : acc_d - 1'b1;
                  rem_d   = '0;
                  cnt_d   = CNT_W'(C_W);
                  state_d = LDIV;
               end
            end
         end
         LDIV: begin
            cnt_d = cnt_q - 1'b1;
            if (rt >= {1'b0, n_q}) begin
               rem_d = rt - {1'b0, n_q};
               sh_d  = {sh_q[C_W-2:0], 1'b1};
            end else begin
               rem_d = rt;
               sh_d  = {sh_q[C_W-2:0], 1'b0};
            end
            if (cnt_q == CNT_W'(1)) begin
               phase_d = SQ_ISSUE;
               state_d = MUL_MU;
            end
         end
         MUL_MU: begin
            if (phase_q == SQ_ISSUE) begin
               mm_start = 1'b1;
               phase_d  = SQ_WAIT;
            end else if (mm_done) begin
               out_d   = mm_res[N_W-1:0];
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   paillier_modmul #(
      .W(C_W)
   ) u_mm (
      .clk   (clk),
      .rst   (rst),
      .start (mm_start),
      .a     (mm_a),
      .b     (mm_b),
      .m     (mm_m),
      .result(mm_res),
      .done  (mm_done)
   );

   assign out  = out_q;
   assign done = done_q;
   assign err  = err_q;
   assign busy = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/paillier_decrypt_param.md
Name: paillier_decrypt_param

Overview:
Parametrised, multi-cycle Paillier decryption engine: m = L(c^lambda mod n^2) * mu mod n, with L(x) = (x-1)/n and n = p*q formed internally. It is the width-generic successor of the fixed 32/128-bit decryption unit. It adds a busy/done/err handshake, input validation and a shared modular-multiplier sub-module. It sits behind the key/ciphertext register block and feeds the plaintext result register.

Parameters:
P_W, 32, width of primes p and q
N_W, 2*P_W, width of n, lambda, mu and plaintext out (derived; do not override)
C_W, 2*N_W, width of ciphertext and of n^2 (derived; do not override)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset
start  in  1  request; sampled only in IDLE or DONE
cipher_text  in  C_W  ciphertext c
p  in  P_W  prime p
q  in  P_W  prime q
lambda  in  N_W  private exponent
mu  in  N_W  precomputed inverse L(g^lambda mod n^2)^-1 mod n
out  out  N_W  plaintext m
done  out  1  result valid (level)
busy  out  1  computation in progress
err  out  1  invalid-input flag, valid with done

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. On reset: state IDLE, out=0, done=0, busy=0, err=0, all internal registers 0.
- Reset mid-operation aborts at the next edge; no partial result is exposed.
- Inputs are latched on the start-accept edge. Later changes to the inputs have no effect until the next accept.
- start is accepted in IDLE or DONE: done and err clear, busy sets on the same edge. start while busy is ignored.
- FSM sequence:
  - IDLE
  - MUL_N: n = p*q, shift-add, P_W cycles
  - MUL_NSQ: n^2 = n*n, N_W cycles
  - CHECK: 1 cycle
  - EXP: left-to-right square-and-multiply over all N_W bits of lambda, MSB first; acc starts at 1; each bit does a modmul square and, if the bit is 1, a modmul multiply, both mod n^2
  - LDIV: restoring divide of (acc-1) by n, C_W cycles; the remainder is discarded
  - MUL_MU: modmul(L, mu) mod n
  - DONE
- CHECK goes straight to DONE with err=1 and out=0 if any of these holds: n==0, n==1, c==0, or c>=n^2.
- lambda==0 gives acc=1, L=0, out=0 with err=0.
- In DONE, out and done stay stable until the next accepted start or rst; busy=0 there.
- All intermediates are held at C_W bits; modmul operands are always reduced below the modulus.
- Maximum latency from accept to done: about P_W + N_W + 1 + 2*N_W*(C_W+2) + C_W + (C_W+2) cycles. The bench bounds its wait by this; it does not depend on an exact count.

Decomposition:
- paillier_pkg holds:
  - the FSM state enum (IDLE, MUL_N, MUL_NSQ, CHECK, EXP, LDIV, MUL_MU, DONE)
  - width-derivation helpers for N_W and C_W
- Sub-module paillier_modmul, parameter W:
  - interleaved MSB-first shift-add modular multiply, a*b mod m
  - ports clk, rst, start, a, b, m, result, done
  - W+2 cycles per operation; done is a 1-cycle pulse
  - one instance at W=C_W, shared by EXP and MUL_MU (the top zero-extends mu and n for MUL_MU)
- Integer multiply and divide stay in the top level.

Test Plan:
- p=13, q=7, lambda=12, mu=38, c=456 -> done=1, out=5, err=0.
- Same key, c=7825 (m=5, r=90) -> out=5. Same key, c=1 -> out=0. Same key, c=8191 -> out=90.
- Same key, c=7086447 (exceeds n^2=8281) -> done=1, err=1, out=0 within 4 cycles of CHECK entry. c=0 -> err=1.
- Re-assert start while busy after 20 cycles with a changed c -> ignored; original result 5 returned. start in DONE with c=1 -> done drops on the accept edge, then out=0.
- rst pulsed mid-EXP -> next edge gives busy=0, done=0, out=0. A following start with c=456 completes normally with out=5.
- P_W=8 instance, same key vectors -> identical outputs. lambda=0 -> out=0, err=0.
